// File: rtl/encaps_sequencer.sv
// Control sequencer for one encapsulation: key unpack, accumulator clear,
// coefficient sampling/multiply/lift, then hashing, with wait timeouts.
module encaps_sequencer #(
  parameter int N_COEF  = 700,
  parameter int TIMEOUT = 4095
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       up_done,
  input  logic       hash_fin,
  output logic       unpack_en,
  output logic       enc_clr,
  output logic       sample_en,
  output logic       mul_en,
  output logic       lift_en,
  output logic       hash_start,
  output logic [9:0] coef_idx,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int              WW         = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0]   WAIT_LIMIT = WW'(TIMEOUT);
  localparam logic [9:0]      LAST_IDX   = 10'(N_COEF - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_CLEAR,
    S_SAMPLE,
    S_HASH,
    S_DONE,
    S_ERR
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [WW-1:0] wait_cnt;

  // Wait counter restarts on every state change, so it is zero on entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      coef_idx <= '0;
    end else begin
      state <= state_next;
      if (state_next != state)
        wait_cnt <= '0;
      else if (state == S_UNPACK || state == S_HASH)
        wait_cnt <= wait_cnt + 1'b1;
      if (state == S_SAMPLE && coef_idx != LAST_IDX)
        coef_idx <= coef_idx + 1'b1;
      else
        coef_idx <= '0;
    end
  end

  // Outputs depend only on state and counters; inputs steer state_next.
  always_comb begin
    state_next = state;
    unpack_en  = 1'b0;
    enc_clr    = 1'b0;
    sample_en  = 1'b0;
    mul_en     = 1'b0;
    lift_en    = 1'b0;
    hash_start = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_UNPACK;
      end
      S_UNPACK: begin
        unpack_en = 1'b1;
        busy      = 1'b1;
        if (up_done)                      state_next = S_CLEAR;
        else if (wait_cnt == WAIT_LIMIT)  state_next = S_ERR;
      end
      S_CLEAR: begin
        enc_clr    = 1'b1;
        busy       = 1'b1;
        state_next = S_SAMPLE;
      end
      S_SAMPLE: begin
        sample_en = 1'b1;
        mul_en    = 1'b1;
        lift_en   = 1'b1;
        busy      = 1'b1;
        if (coef_idx == LAST_IDX) state_next = S_HASH;
      end
      S_HASH: begin
        busy       = 1'b1;
        hash_start = (wait_cnt == '0);
        // A finish flag seen on the launch cycle is stale and must not count.
        if (hash_fin && wait_cnt != '0)  state_next = S_DONE;
        else if (wait_cnt == WAIT_LIMIT) state_next = S_ERR;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_next = S_UNPACK;
      end
      S_ERR: begin
        err = 1'b1;
        if (start) state_next = S_UNPACK;
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_encaps_sequencer.sv
// Directed self-checking bench: nominal 700-coefficient instance and a short
// instance with TIMEOUT=15 for the timeout and race cases.
module tb_encaps_sequencer;

  logic clk = 1'b0;
  logic rst_n;

  logic start_a, up_done_a, hash_fin_a;
  logic unpack_en_a, enc_clr_a, sample_en_a, mul_en_a, lift_en_a, hash_start_a;
  logic [9:0] coef_idx_a;
  logic busy_a, done_a, err_a;

  logic start_b, up_done_b, hash_fin_b;
  logic unpack_en_b, enc_clr_b, sample_en_b, mul_en_b, lift_en_b, hash_start_b;
  logic [9:0] coef_idx_b;
  logic busy_b, done_b, err_b;

  logic [18:0] outs_a;
  logic [18:0] outs_b;

  int check_count = 0;
  int pass_count  = 0;
  int errs;
  int extra;
  int n;

  assign outs_a = {unpack_en_a, enc_clr_a, sample_en_a, mul_en_a, lift_en_a,
                   hash_start_a, coef_idx_a, busy_a, done_a, err_a};
  assign outs_b = {unpack_en_b, enc_clr_b, sample_en_b, mul_en_b, lift_en_b,
                   hash_start_b, coef_idx_b, busy_b, done_b, err_b};

  always #5 clk = ~clk;

  encaps_sequencer #(.N_COEF(700), .TIMEOUT(4095)) u_nom (
    .clk(clk), .rst_n(rst_n), .start(start_a), .up_done(up_done_a),
    .hash_fin(hash_fin_a), .unpack_en(unpack_en_a), .enc_clr(enc_clr_a),
    .sample_en(sample_en_a), .mul_en(mul_en_a), .lift_en(lift_en_a),
    .hash_start(hash_start_a), .coef_idx(coef_idx_a), .busy(busy_a),
    .done(done_a), .err(err_a)
  );

  encaps_sequencer #(.N_COEF(8), .TIMEOUT(15)) u_short (
    .clk(clk), .rst_n(rst_n), .start(start_b), .up_done(up_done_b),
    .hash_fin(hash_fin_b), .unpack_en(unpack_en_b), .enc_clr(enc_clr_b),
    .sample_en(sample_en_b), .mul_en(mul_en_b), .lift_en(lift_en_b),
    .hash_start(hash_start_b), .coef_idx(coef_idx_b), .busy(busy_b),
    .done(done_b), .err(err_b)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed === expected) pass_count++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic applyStimulus();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    start_a = 1'b0; up_done_a = 1'b0; hash_fin_a = 1'b0;
    start_b = 1'b0; up_done_b = 1'b0; hash_fin_b = 1'b0;
    repeat (3) applyStimulus();
    checkOutput("reset_outputs_a", 32'(outs_a), 0);
    checkOutput("reset_outputs_b", 32'(outs_b), 0);

    rst_n = 1'b1; start_a = 1'b1;
    applyStimulus();
    start_a = 1'b0;
    checkOutput("unpack_en_after_start", 32'(unpack_en_a), 1);
    checkOutput("busy_in_unpack", 32'(busy_a), 1);
    repeat (4) applyStimulus();
    up_done_a = 1'b1;
    applyStimulus();
    up_done_a = 1'b0;
    checkOutput("enc_clr_pulse", 32'(enc_clr_a), 1);
    checkOutput("sample_off_in_clear", 32'(sample_en_a), 0);
    applyStimulus();
    checkOutput("first_coef_idx", 32'(coef_idx_a), 0);

    errs = 0; extra = 0;
    for (int i = 0; i < 700; i++) begin
      if (!(sample_en_a && mul_en_a && lift_en_a) || coef_idx_a != 10'(i)) errs++;
      if (enc_clr_a || hash_start_a) extra++;
      start_a = (i == 100);
      applyStimulus();
    end
    start_a = 1'b0;
    checkOutput("sample_seq_errors", 32'(errs), 0);
    checkOutput("stray_pulses_in_sample", 32'(extra), 0);
    checkOutput("hash_start_first_cycle", 32'(hash_start_a), 1);
    checkOutput("sample_off_in_hash", 32'(sample_en_a), 0);
    checkOutput("coef_idx_after_sample", 32'(coef_idx_a), 0);

    hash_fin_a = 1'b1;
    applyStimulus();
    hash_fin_a = 1'b0;
    checkOutput("early_hash_fin_busy", 32'(busy_a), 1);
    checkOutput("early_hash_fin_done", 32'(done_a), 0);
    checkOutput("hash_start_single", 32'(hash_start_a), 0);
    extra = 0;
    repeat (29) begin
      if (hash_start_a || done_a) extra++;
      applyStimulus();
    end
    checkOutput("hash_wait_stray", 32'(extra), 0);
    hash_fin_a = 1'b1;
    applyStimulus();
    hash_fin_a = 1'b0;
    checkOutput("nominal_done", 32'(done_a), 1);
    checkOutput("nominal_busy", 32'(busy_a), 0);
    repeat (2) applyStimulus();
    checkOutput("done_held", 32'(done_a), 1);

    start_a = 1'b1;
    applyStimulus();
    start_a = 1'b0;
    checkOutput("b2b_done_drop", 32'(done_a), 0);
    checkOutput("b2b_unpack_en", 32'(unpack_en_a), 1);

    up_done_a = 1'b1;
    applyStimulus();
    up_done_a = 1'b0;
    applyStimulus();
    repeat (350) applyStimulus();
    checkOutput("coef_idx_before_reset", 32'(coef_idx_a), 350);
    rst_n = 1'b0; start_a = 1'b1; up_done_a = 1'b1;
    applyStimulus();
    up_done_a = 1'b0;
    checkOutput("mid_sample_reset_outputs", 32'(outs_a), 0);
    rst_n = 1'b1;
    applyStimulus();
    start_a = 1'b0;
    checkOutput("start_after_reset", 32'(unpack_en_a), 1);
    up_done_a = 1'b1;
    applyStimulus();
    up_done_a = 1'b0;
    applyStimulus();
    n = 0;
    while (sample_en_a && n < 800) begin
      n++;
      applyStimulus();
    end
    checkOutput("sample_len_after_reset", 32'(n), 700);

    start_b = 1'b1;
    applyStimulus();
    start_b = 1'b0;
    n = 0; extra = 0;
    while (unpack_en_b && n < 40) begin
      if (enc_clr_b || sample_en_b) extra++;
      n++;
      applyStimulus();
    end
    checkOutput("unpack_timeout_cycles", 32'(n), 16);
    checkOutput("unpack_timeout_err", 32'(err_b), 1);
    checkOutput("unpack_timeout_busy", 32'(busy_b), 0);
    checkOutput("unpack_timeout_stray", 32'(extra + int'(enc_clr_b) + int'(sample_en_b)), 0);

    start_b = 1'b1;
    applyStimulus();
    start_b = 1'b0;
    checkOutput("restart_err_clear", 32'(err_b), 0);
    checkOutput("restart_unpack_en", 32'(unpack_en_b), 1);
    repeat (15) applyStimulus();
    checkOutput("unpack_last_wait_cycle", 32'(unpack_en_b), 1);
    up_done_b = 1'b1;
    applyStimulus();
    up_done_b = 1'b0;
    checkOutput("up_done_wins_timeout", 32'(enc_clr_b), 1);
    checkOutput("up_done_wins_no_err", 32'(err_b), 0);
    applyStimulus();
    repeat (8) applyStimulus();
    checkOutput("short_hash_start", 32'(hash_start_b), 1);
    repeat (15) applyStimulus();
    hash_fin_b = 1'b1;
    applyStimulus();
    hash_fin_b = 1'b0;
    checkOutput("hash_fin_wins_done", 32'(done_b), 1);
    checkOutput("hash_fin_wins_no_err", 32'(err_b), 0);

    start_b = 1'b1;
    applyStimulus();
    start_b = 1'b0;
    up_done_b = 1'b1;
    applyStimulus();
    up_done_b = 1'b0;
    applyStimulus();
    repeat (8) applyStimulus();
    repeat (15) applyStimulus();
    checkOutput("hash_last_wait_busy", 32'(busy_b), 1);
    applyStimulus();
    checkOutput("hash_timeout_err", 32'(err_b), 1);
    checkOutput("hash_timeout_no_done", 32'(done_b), 0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/encaps_sequencer.md
ENCAPS_SEQUENCER -- requirements
Module: encaps_sequencer

Interface
REQ-001 SHALL have parameter N_COEF, default 700, meaning coefficients sampled and multiplied per encapsulation.
REQ-002 SHALL have parameter TIMEOUT, default 4095, meaning maximum cycles spent waiting in UNPACK or HASH.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: request one encapsulation; sampled only in IDLE, DONE or ERR.
REQ-006 SHALL have port up_done, input, 1 bit: public-key unpack complete; sampled only in UNPACK.
REQ-007 SHALL have port hash_fin, input, 1 bit: SHA3-256 finished; sampled only in HASH.
REQ-008 SHALL have port unpack_en, output, 1 bit: unpack datapath enable.
REQ-009 SHALL have port enc_clr, output, 1 bit: one-cycle clear of the multiplier and lift accumulators.
REQ-010 SHALL have port sample_en, output, 1 bit: ternary sampler advance, one r/m coefficient pair per cycle.
REQ-011 SHALL have port mul_en, output, 1 bit: polynomial multiply accumulate enable.
REQ-012 SHALL have port lift_en, output, 1 bit: lift accumulate enable.
REQ-013 SHALL have port hash_start, output, 1 bit: one-cycle pulse launching the hash.
REQ-014 SHALL have port coef_idx, output, 10 bits: index of the coefficient currently sampled.
REQ-015 SHALL have port busy, output, 1 bit: high in every state except IDLE, DONE and ERR.
REQ-016 SHALL have port done, output, 1 bit: key and ciphertext valid; held until the next start.
REQ-017 SHALL have port err, output, 1 bit: timeout occurred; held until the next start.

Function
REQ-018 SHALL implement a registered FSM with states IDLE, UNPACK, CLEAR, SAMPLE, HASH, DONE, ERR.
REQ-019 SHALL decode all outputs from registered state and counters only, with no combinational input-to-output path.
REQ-020 SHALL move IDLE->UNPACK on the first edge with start=1, and SHALL hold unpack_en=1 throughout UNPACK.
REQ-021 SHALL move UNPACK->CLEAR on the edge where up_done=1, and SHALL hold CLEAR exactly one cycle with enc_clr=1.
REQ-022 SHALL move CLEAR->SAMPLE unconditionally, with coef_idx=0 on the first SAMPLE cycle.
REQ-023 SHALL hold sample_en, mul_en and lift_en all at 1 on every SAMPLE cycle, and SHALL increment coef_idx by 1 per cycle.
REQ-024 SHALL stay in SAMPLE for exactly N_COEF cycles, i.e. while coef_idx runs 0..N_COEF-1.
REQ-025 SHALL move SAMPLE->HASH on the cycle with coef_idx=N_COEF-1, and SHALL reset coef_idx to 0 on that transition.
REQ-026 SHALL assert hash_start for exactly the first HASH cycle.
REQ-027 SHALL move HASH->DONE on the edge where hash_fin=1, provided that edge is not the hash_start cycle; hash_fin on the hash_start cycle SHALL be ignored.
REQ-028 SHALL run a wait counter in UNPACK and HASH: cleared on state entry, incremented each cycle.
REQ-029 SHALL move to ERR when the wait counter reaches TIMEOUT and the awaited input is 0; when both occur on the same edge, the input SHALL win.
REQ-030 SHALL, in DONE or ERR with start=1, clear done and err and enter UNPACK on the next edge (back-to-back operation).
REQ-031 SHALL ignore start while busy=1.
REQ-032 SHALL assert enc_clr in no state other than CLEAR.
REQ-033 SHALL never assert sample_en, mul_en or lift_en outside SAMPLE.
REQ-034 SHALL produce a minimum total latency from start to done of 1 + U + 1 + N_COEF + H + 1 cycles, where U and H are the cycles spent waiting for up_done and hash_fin.

Reset
REQ-035 SHALL, on a clock edge with rst_n=0, enter IDLE from any state, including mid-SAMPLE or mid-HASH.
REQ-036 SHALL, on that reset edge, force every output, the wait counter and coef_idx to 0.
REQ-037 SHALL let reset take priority over start, up_done and hash_fin.
REQ-038 SHALL require no further reset cycles: start is honoured on the first edge with rst_n=1.

Verification
REQ-039 Nominal run (N_COEF=700), start pulse, up_done after 5 cycles, hash_fin 30 cycles after hash_start -> exactly one enc_clr pulse, 700 sample_en cycles with coef_idx 0..699, one hash_start pulse, done=1 and busy=0.
REQ-040 Unpack timeout (TIMEOUT=15), up_done held 0 -> err=1 on the 16th UNPACK cycle; no enc_clr and no sample_en.
REQ-041 Reset at coef_idx=350 -> next cycle IDLE, all outputs 0; a following start runs a full 700-cycle SAMPLE.
REQ-042 Premature and simultaneous inputs: hash_fin=1 on the hash_start cycle -> still HASH; hash_fin on the TIMEOUT edge -> DONE, not ERR.
REQ-043 Back-to-back: start asserted in DONE -> done drops and unpack_en rises on the next edge; start pulses during SAMPLE have no effect.
